// File: rtl/gemm_tile_sequencer.sv
// Control sequencer for the tiled output-stationary GEMM array.
// Walks output tiles row-major (tile_n innermost). For each tile it issues K
// A/B read addresses, aligns MAC enable/clear to the SRAM read latency, drains
// the pipeline, then writes one C word through a ready handshake.
// Optional feature macro: GEMM_TILE_SEQ_PERF_CNT_EN (busy/stall perf counters).
module gemm_tile_sequencer #(
  parameter int unsigned RowPar        = 4,
  parameter int unsigned ColPar        = 16,
  parameter int unsigned AddrWidth     = 12,
  parameter int unsigned SizeAddrWidth = 32,
  parameter int unsigned MemLatency    = 1,
  parameter int unsigned MacLatency    = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  input  logic [AddrWidth-1:0]     a_base_i,
  input  logic [AddrWidth-1:0]     b_base_i,
  input  logic [AddrWidth-1:0]     c_base_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o,
  input  logic                     c_ready_i,
  output logic                     mac_en_o,
  output logic                     mac_first_o,
  output logic                     busy_o,
  output logic                     done_o,
`ifdef GEMM_TILE_SEQ_PERF_CNT_EN
  output logic [31:0]              perf_cycles_o,
  output logic [31:0]              perf_stall_o,
`endif
  output logic                     err_o
);

  localparam int unsigned DrainCycles = MemLatency + MacLatency;
  localparam int unsigned DrainW      = $clog2(DrainCycles + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_LOAD, S_DRAIN, S_WRITE, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [SizeAddrWidth-1:0] m_q, k_q, n_q;
  logic [AddrWidth-1:0]     a_base_q, b_base_q, c_base_q;
  logic [SizeAddrWidth-1:0] tile_m_q, tile_n_q, k_cnt_q;
  logic [AddrWidth-1:0]     a_row_q, b_row_q, c_addr_q;
  logic [DrainW-1:0]        drain_q;
  logic [MemLatency-1:0]    en_pipe_q, first_pipe_q;

  logic [SizeAddrWidth-1:0] mt, nt;
  logic size_bad, last_k, last_n, last_m, drain_last, accept;

  assign mt         = m_q / SizeAddrWidth'(RowPar);
  assign nt         = n_q / SizeAddrWidth'(ColPar);
  assign size_bad   = (m_q == '0) || (k_q == '0) || (n_q == '0) ||
                      ((m_q % SizeAddrWidth'(RowPar)) != '0) ||
                      ((n_q % SizeAddrWidth'(ColPar)) != '0);
  assign last_k     = (k_cnt_q == k_q - 1'b1);
  assign last_n     = (tile_n_q == nt - 1'b1);
  assign last_m     = (tile_m_q == mt - 1'b1);
  assign drain_last = (drain_q == DrainW'(DrainCycles - 1));
  assign accept     = (state_q == S_WRITE) && c_ready_i;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    sram_a_addr_o = '0;
    sram_b_addr_o = '0;
    sram_c_addr_o = '0;
    sram_c_we_o   = 1'b0;
    done_o        = 1'b0;
    err_o         = 1'b0;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_CHECK;
      S_CHECK: state_d = size_bad ? S_DONE : S_LOAD;
      S_LOAD: begin
        sram_a_addr_o = a_row_q + k_cnt_q[AddrWidth-1:0];
        sram_b_addr_o = b_row_q + k_cnt_q[AddrWidth-1:0];
        if (last_k) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // k stays at K-1 here, so the last read address is held.
        sram_a_addr_o = a_row_q + k_cnt_q[AddrWidth-1:0];
        sram_b_addr_o = b_row_q + k_cnt_q[AddrWidth-1:0];
        if (drain_last) state_d = S_WRITE;
      end
      S_WRITE: begin
        sram_c_addr_o = c_addr_q;
        sram_c_we_o   = 1'b1;
        if (c_ready_i) state_d = (last_n && last_m) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        done_o  = 1'b1;
        err_o   = size_bad;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign mac_en_o    = en_pipe_q[MemLatency-1];
  assign mac_first_o = first_pipe_q[MemLatency-1];

  // Operand latch, tile/k/drain counters and running base addresses.
  // Row bases advance by K per tile step instead of multiplying tile*K.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q      <= '0;
      k_q      <= '0;
      n_q      <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      tile_m_q <= '0;
      tile_n_q <= '0;
      k_cnt_q  <= '0;
      a_row_q  <= '0;
      b_row_q  <= '0;
      c_addr_q <= '0;
      drain_q  <= '0;
    end else begin
      if (state_q == S_IDLE && start_i) begin
        m_q      <= M_size_i;
        k_q      <= K_size_i;
        n_q      <= N_size_i;
        a_base_q <= a_base_i;
        b_base_q <= b_base_i;
        c_base_q <= c_base_i;
      end
      if (state_q == S_CHECK) begin
        tile_m_q <= '0;
        tile_n_q <= '0;
        k_cnt_q  <= '0;
        a_row_q  <= a_base_q;
        b_row_q  <= b_base_q;
        c_addr_q <= c_base_q;
      end
      if (state_q == S_LOAD) begin
        if (last_k) drain_q <= '0;
        else        k_cnt_q <= k_cnt_q + 1'b1;
      end
      if (state_q == S_DRAIN) drain_q <= drain_q + 1'b1;
      if (accept) begin
        k_cnt_q  <= '0;
        c_addr_q <= c_addr_q + 1'b1;
        if (last_n) begin
          tile_n_q <= '0;
          tile_m_q <= tile_m_q + 1'b1;
          a_row_q  <= a_row_q + k_q[AddrWidth-1:0];
          b_row_q  <= b_base_q;
        end else begin
          tile_n_q <= tile_n_q + 1'b1;
          b_row_q  <= b_row_q + k_q[AddrWidth-1:0];
        end
      end
    end
  end

  // MAC enable/first delayed by the SRAM read latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_pipe_q    <= '0;
      first_pipe_q <= '0;
    end else begin
      en_pipe_q[0]    <= (state_q == S_LOAD);
      first_pipe_q[0] <= (state_q == S_LOAD) && (k_cnt_q == '0);
      for (int unsigned i = 1; i < MemLatency; i++) begin
        en_pipe_q[i]    <= en_pipe_q[i-1];
        first_pipe_q[i] <= first_pipe_q[i-1];
      end
    end
  end

`ifdef GEMM_TILE_SEQ_PERF_CNT_EN
  // Saturating busy-cycle and write-stall counters, cleared on accepted start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_cycles_o <= '0;
      perf_stall_o  <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      perf_cycles_o <= '0;
      perf_stall_o  <= '0;
    end else begin
      if (busy_o && perf_cycles_o != '1) perf_cycles_o <= perf_cycles_o + 1'b1;
      if (state_q == S_WRITE && !c_ready_i && perf_stall_o != '1)
        perf_stall_o <= perf_stall_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed table-driven bench for gemm_tile_sequencer (default parameters).
module tb_gemm_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] M_size_i, K_size_i, N_size_i;
  logic [11:0] a_base_i, b_base_i, c_base_i;
  logic [11:0] sram_a_addr_o, sram_b_addr_o, sram_c_addr_o;
  logic        sram_c_we_o, c_ready_i, mac_en_o, mac_first_o;
  logic        busy_o, done_o, err_o;
`ifdef GEMM_TILE_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_stall;
`endif

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  gemm_tile_sequencer dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
    .M_size_i(M_size_i), .K_size_i(K_size_i), .N_size_i(N_size_i),
    .a_base_i(a_base_i), .b_base_i(b_base_i), .c_base_i(c_base_i),
    .sram_a_addr_o(sram_a_addr_o), .sram_b_addr_o(sram_b_addr_o),
    .sram_c_addr_o(sram_c_addr_o), .sram_c_we_o(sram_c_we_o),
    .c_ready_i(c_ready_i), .mac_en_o(mac_en_o), .mac_first_o(mac_first_o),
    .busy_o(busy_o), .done_o(done_o),
`ifdef GEMM_TILE_SEQ_PERF_CNT_EN
    .perf_cycles_o(perf_cycles), .perf_stall_o(perf_stall),
`endif
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int unsigned m, k, n;
    logic [11:0] ab, bb, cb;
    int unsigned stall;
    bit          disturb;
    bit          exp_err;
    int unsigned exp_done;
    int unsigned exp_writes;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(int unsigned m, int unsigned k, int unsigned n,
                              int unsigned ab, int unsigned bb, int unsigned cb,
                              int unsigned stall, bit disturb, bit exp_err,
                              int unsigned exp_done, int unsigned exp_writes);
    vec_t v;
    v.m = m; v.k = k; v.n = n;
    v.ab = 12'(ab); v.bb = 12'(bb); v.cb = 12'(cb);
    v.stall = stall; v.disturb = disturb; v.exp_err = exp_err;
    v.exp_done = exp_done; v.exp_writes = exp_writes;
    return v;
  endfunction

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs_zero(input string name);
    logic [41:0] o;
    o = {sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o,
         mac_en_o, mac_first_o, busy_o, done_o, err_o};
    chk(name, o, 0);
  endtask

  // Applies the operands and pulses start; returns #1 after the start edge.
  task automatic start_run(input vec_t v);
    @(posedge clk); #1;
    M_size_i = v.m; K_size_i = v.k; N_size_i = v.n;
    a_base_i = v.ab; b_base_i = v.bb; c_base_i = v.cb;
    c_ready_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run_case(input vec_t v, input string tag);
    int unsigned done_cyc, err_seen, writes, we_cyc, en_cnt, first_cnt;
    int unsigned mac_errs, c_errs, stall_left, nt, tiles, busy1;
    int unsigned t_idx, kk, tm, tn;
    logic [11:0] pa, pb, ea, eb, ec;
    done_cyc = 0; err_seen = 0; writes = 0; we_cyc = 0; en_cnt = 0;
    first_cnt = 0; mac_errs = 0; c_errs = 0; busy1 = 0;
    stall_left = v.stall;
    nt = v.n / 16;
    tiles = v.exp_err ? 0 : (v.m / 4) * nt;
    pa = '0; pb = '0;
    start_run(v);
    for (int unsigned cyc = 1; cyc <= 3000; cyc++) begin
      @(posedge clk); #1;
      if (v.disturb && cyc == 5) begin
        start_i = 1'b1; M_size_i = 30; K_size_i = 0; a_base_i = 12'd7;
      end
      if (v.disturb && cyc == 6) start_i = 1'b0;
      if (cyc == 1) busy1 = busy_o;
      if (sram_c_we_o && stall_left > 0) begin
        c_ready_i = 1'b0;
        stall_left--;
      end else begin
        c_ready_i = 1'b1;
      end
      if (sram_c_we_o) begin
        we_cyc++;
        if (c_ready_i) begin
          if (nt == 0) c_errs++;
          else begin
            tm = writes / nt; tn = writes % nt;
            ec = 12'(v.cb + tm * nt + tn);
            if (sram_c_addr_o != ec) begin
              c_errs++;
              $display("FAIL %s c_addr[%0d]: got %0d expected %0d", tag, writes, sram_c_addr_o, ec);
            end
          end
          writes++;
        end
      end
      if (mac_en_o) begin
        if (v.k == 0 || nt == 0) mac_errs++;
        else begin
          t_idx = en_cnt / v.k; kk = en_cnt % v.k;
          tm = t_idx / nt; tn = t_idx % nt;
          ea = 12'(v.ab + tm * v.k + kk);
          eb = 12'(v.bb + tn * v.k + kk);
          if (pa != ea || pb != eb || mac_first_o != (kk == 0)) begin
            mac_errs++;
            if (mac_errs < 4)
              $display("FAIL %s mac[%0d]: got a=%0d b=%0d first=%0d expected a=%0d b=%0d first=%0d",
                       tag, en_cnt, pa, pb, mac_first_o, ea, eb, (kk == 0));
          end
        end
        en_cnt++;
        if (mac_first_o) first_cnt++;
      end else if (mac_first_o) begin
        mac_errs++;
      end
      pa = sram_a_addr_o; pb = sram_b_addr_o;
      if (done_o) begin
        done_cyc = cyc;
        err_seen = err_o;
        break;
      end
    end
    if (done_cyc == 0) $display("FAIL %s timeout: done_o never seen", tag);
    chk({tag, " busy_at_check"}, busy1, 1);
    chk({tag, " done_cycle"}, done_cyc, v.exp_done);
    chk({tag, " err"}, err_seen, v.exp_err);
    chk({tag, " writes"}, writes, v.exp_writes);
    chk({tag, " c_addr_errs"}, c_errs, 0);
    chk({tag, " we_cycles"}, we_cyc, v.exp_writes + (v.exp_err ? 0 : v.stall));
    chk({tag, " mac_en_cycles"}, en_cnt, tiles * v.k);
    chk({tag, " mac_first_cycles"}, first_cnt, tiles);
    chk({tag, " mac_addr_errs"}, mac_errs, 0);
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, done_o, 0);
    chk({tag, " idle_after"}, busy_o, 0);
  endtask

  initial begin
    vecs[0] = mk(32, 32, 32,   0,   0,    0, 0, 0, 0, 561, 16);
    vecs[1] = mk( 8,  3, 16, 100, 200, 4000, 0, 0, 0,  13,  2);
    vecs[2] = mk(32, 32, 32,   0,   0,    0, 3, 0, 0, 564, 16);
    vecs[3] = mk(30, 32, 32,   0,   0,    0, 0, 0, 1,   1,  0);
    vecs[4] = mk(32,  0, 32,   0,   0,    0, 0, 0, 1,   1,  0);
    vecs[5] = mk( 8,  2, 32,   0,   0, 4094, 0, 0, 0,  21,  4);
    vecs[6] = mk( 8,  3, 16, 100, 200, 4000, 0, 1, 0,  13,  2);

    rst_ni = 1'b0; start_i = 1'b0; c_ready_i = 1'b1;
    M_size_i = '0; K_size_i = '0; N_size_i = '0;
    a_base_i = '0; b_base_i = '0; c_base_i = '0;
    #3;
    chk_outs_zero("reset_outputs");
    @(posedge clk); @(posedge clk); #2;
    rst_ni = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_case(vecs[i], $sformatf("vec%0d", i));
`ifdef GEMM_TILE_SEQ_PERF_CNT_EN
      if (i == 2) begin
        chk("perf_stall", perf_stall, 3);
        chk("perf_cycles", perf_cycles, 565);
      end
`endif
    end

    // Asynchronous reset in the middle of tile 2 (tile_m=1, tile_n=0), k=1.
    start_run(vecs[0]);
    repeat (72) @(posedge clk);
    #1;
    chk("pre_reset_a_addr", sram_a_addr_o, 33);
    chk("pre_reset_b_addr", sram_b_addr_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk_outs_zero("async_reset_outputs");
    @(posedge clk); #1;
    chk("reset_no_write", sram_c_we_o, 0);
    @(posedge clk); #2;
    rst_ni = 1'b1;
    run_case(vecs[1], "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/gemm_tile_sequencer.md
Name: gemm_tile_sequencer

Overview:
- Runtime-sized control sequencer for the tiled output-stationary GEMM array.
- Walks (tile_m, tile_n) output tiles in row-major order, tile_n innermost.
- Per tile: issues K A/B SRAM read addresses, aligns MAC enable/clear to read latency, drains, then writes one packed C tile through a ready handshake.
- Successor to the fixed-geometry controller: relocatable base addresses, parametrised memory/MAC latency, size checking, write back-pressure.

Parameters:
- RowPar, 4, rows per tile (A word holds RowPar int8).
- ColPar, 16, columns per tile (B word holds ColPar int8).
- AddrWidth, 12, SRAM address width (A, B, C).
- SizeAddrWidth, 32, width of M/K/N size inputs.
- MemLatency, 1, SRAM read latency in cycles (>=1).
- MacLatency, 1, cycles from last mac_en_o to valid accumulator output (>=0).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- start_i  in  1  start pulse, sampled only in IDLE
- M_size_i  in  SizeAddrWidth  rows of A/C
- K_size_i  in  SizeAddrWidth  reduction depth
- N_size_i  in  SizeAddrWidth  cols of B/C
- a_base_i  in  AddrWidth  A base address
- b_base_i  in  AddrWidth  B base address
- c_base_i  in  AddrWidth  C base address
- sram_a_addr_o  out  AddrWidth  A read address
- sram_b_addr_o  out  AddrWidth  B read address
- sram_c_addr_o  out  AddrWidth  C write address
- sram_c_we_o  out  1  C write enable
- c_ready_i  in  1  C write accepted this cycle
- mac_en_o  out  1  array accumulates current A/B data
- mac_first_o  out  1  with mac_en_o: overwrite instead of accumulate (k=0)
- busy_o  out  1  high from CHECK through DONE
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse coincident with done_o on illegal sizes

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; sizes/bases latched 0. Reset mid-run aborts immediately with no further writes.
- Sizes and bases are latched on the accepted start_i. Inputs may change afterwards without effect.
- Derived values: MT=M/RowPar, NT=N/ColPar, T=MT*NT.
- Address formulas:
  - A = a_base + tile_m*K + k
  - B = b_base + tile_n*K + k
  - C = c_base + tile_m*NT + tile_n
- All addresses wrap modulo 2^AddrWidth.
- States:
  - IDLE: start_i=1 -> CHECK. start_i is ignored in every other state.
  - CHECK (1 cycle): if M, K or N is 0, or M%RowPar!=0, or N%ColPar!=0 -> DONE with err. Otherwise tile_m=tile_n=k=0 -> LOAD.
  - LOAD (K cycles): present A/B addresses for k. k++. Leave after k=K-1 -> DRAIN.
  - DRAIN (MemLatency+MacLatency cycles): addresses held at last value -> WRITE.
  - WRITE: sram_c_we_o=1, C address valid. Hold both until c_ready_i=1. On that cycle advance tile_n, wrapping into tile_m. If this was the last tile -> DONE, else -> LOAD with k=0.
  - DONE (1 cycle): done_o=1, err_o=error flag -> IDLE.
- mac_en_o and mac_first_o come from a MemLatency-deep shift of (in_LOAD, k==0). mac_en_o is high exactly K cycles per tile, the first being MemLatency cycles after the tile's first LOAD cycle.
- sram_a/b_addr_o are 0 outside LOAD/DRAIN. sram_c_addr_o is 0 outside WRITE.
- Timing with c_ready_i tied high: start_i sampled at edge 0 -> done_o high in the cycle after edge 1+T*(K+MemLatency+MacLatency+1).
- c_ready_i low adds one cycle per low cycle in WRITE. c_ready_i outside WRITE is ignored.
- Error run: done_o and err_o are both high 2 cycles after the start edge. No SRAM write occurs and mac_en_o stays 0.

Optional Feature:
- Macro: GEMM_TILE_SEQ_PERF_CNT_EN.
- Enabled: adds outputs perf_cycles_o[31:0] and perf_stall_o[31:0].
  - Both clear on accepted start.
  - perf_cycles_o counts cycles while busy_o=1; perf_stall_o counts WRITE cycles with c_ready_i=0.
  - Both saturate at 2^32-1 and hold after done until the next start.
- Disabled: ports and logic absent; all other behaviour identical.

Test Plan:
- M=K=N=32, RowPar 4, ColPar 16, bases 0, c_ready_i=1 -> 16 writes at C addresses 0..15 in order. Tile 5 reads A addr 64..95 and B addr 32..63. done_o pulses in the cycle after edge 561. C results match the software golden GEMM.
- M=8, K=3, N=16, a_base=100, b_base=200, c_base=4000 -> A addrs 100..102 then 103..105, B 200..202 twice, C writes 4000 and 4001. mac_en_o is high 3 cycles/tile, mac_first_o once/tile.
- Same as scenario 1 but c_ready_i low for 3 cycles at the first WRITE -> we/address held 4 cycles, done_o 3 cycles later, no duplicate write.
- M=30 (and separately K=0) -> err_o=done_o=1 two cycles after start, sram_c_we_o never asserted, then a legal start runs normally.
- rst_ni low mid-LOAD of tile 2 -> all outputs 0 asynchronously. After release, a new start completes correctly. start_i pulses while busy are ignored.
- c_base=4094 with 4 tiles -> C addresses 4094, 4095, 0, 1. With the macro enabled, scenario 3 gives perf_stall_o=3 and perf_cycles_o=busy cycle count.
